// File: rtl/bist_sequencer.sv
// Run controller for the bus-invert test datapath: injects N_WORDS words, staggers the stage
// enables through a 5-deep valid pipe, counts compare mismatches and signals end of run.
module bist_sequencer #(
   parameter int N_WORDS = 2000,
   parameter int CNT_W   = 11,
   parameter int ERR_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             isequal,
   output logic             en_gen_data,
   output logic             en_enc,
   output logic             en_bus,
   output logic             en_dec,
   output logic             en_trans_count,
   output logic             en_k_comp,
   output logic             done,
   output logic             busy,
   output logic [ERR_W-1:0] err_count,
   output logic             pass
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_WORDS - 1);
   localparam logic [ERR_W-1:0] ERR_MAX   = '1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [4:0]       vpipe_q;
   logic [ERR_W-1:0] err_q, err_d;
   logic             pass_q, pass_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         word_cnt_q <= '0;
         vpipe_q    <= '0;
         err_q      <= '0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         vpipe_q    <= {vpipe_q[3:0], en_gen_data};
         err_q      <= err_d;
         pass_q     <= pass_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      err_d      = err_q;
      pass_d     = pass_q;
      // vpipe_q[4] marks the cycle in which isequal belongs to a real word
      if (vpipe_q[4] && !isequal && err_q != ERR_MAX)
         err_d = err_q + 1'b1;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = RUN;
               word_cnt_d = '0;
               err_d      = '0;
               pass_d     = 1'b0;
            end
         end
         RUN: begin
            if (word_cnt_q == LAST_WORD || abort)
               state_d = DRAIN;
            else
               word_cnt_d = word_cnt_q + 1'b1;
         end
         DRAIN: begin
            // err_q is final here: the last strobe was resolved on the previous edge
            if (vpipe_q == '0) begin
               state_d = DONE;
               pass_d  = (err_q == '0);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign en_gen_data    = (state_q == RUN);
   assign en_enc         = vpipe_q[0];
   assign en_bus         = vpipe_q[1];
   assign en_dec         = vpipe_q[2];
   assign en_trans_count = vpipe_q[2];
   assign en_k_comp      = vpipe_q[3];
   assign done           = (state_q == DONE);
   assign busy           = (state_q == RUN) || (state_q == DRAIN);
   assign err_count      = err_q;
   assign pass           = pass_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Scoreboarded bench for bist_sequencer: each run pushes its expected end-of-run result,
// a negedge monitor checks stage staggering every cycle and pops on each done pulse.
module tb_bist_sequencer;

   localparam int NW = 10;
   localparam int EW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          isequal = 1'b1;
   logic          en_gen_data, en_enc, en_bus, en_dec, en_trans_count, en_k_comp;
   logic          done, busy, pass;
   logic [EW-1:0] err_count;

   bist_sequencer #(.N_WORDS(NW), .CNT_W(4), .ERR_W(EW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .isequal(isequal),
      .en_gen_data(en_gen_data), .en_enc(en_enc), .en_bus(en_bus), .en_dec(en_dec),
      .en_trans_count(en_trans_count), .en_k_comp(en_k_comp), .done(done), .busy(busy),
      .err_count(err_count), .pass(pass)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int words;
      int err;
      int pss;
      int lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass = 0;
   int   n_tot  = 0;
   int   start_cyc = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   // ---------------- monitor ----------------
   logic [3:0] hist = '0;
   int gens = 0, trans = 0, kcomps = 0, strobes = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         hist = '0;
         gens = 0; trans = 0; kcomps = 0; strobes = 0;
      end else begin
         chk("en_enc_stagger", int'(en_enc), int'(hist[0]));
         chk("en_bus_stagger", int'(en_bus), int'(hist[1]));
         chk("en_dec_stagger", int'(en_dec), int'(hist[2]));
         chk("en_trans_stagger", int'(en_trans_count), int'(hist[2]));
         chk("en_k_comp_stagger", int'(en_k_comp), int'(hist[3]));
         if (en_gen_data) gens++;
         if (en_trans_count) trans++;
         if (en_k_comp) kcomps++;
         if (hist[3]) strobes++;
         hist = {hist[2:0], en_gen_data};
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("gen_words", gens, e.words);
               chk("trans_words", trans, e.words);
               chk("kcomp_words", kcomps, e.words);
               chk("strobes", strobes, e.words);
               chk("done_latency", cyc - start_cyc, e.lat);
               chk("err_at_done", int'(err_count), e.err);
               chk("pass_at_done", int'(pass), e.pss);
               chk("busy_at_done", int'(busy), 0);
            end
            gens = 0; trans = 0; kcomps = 0; strobes = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   // nw: words expected to be injected; ab: offset of abort pulse (<0 none);
   // bad: offsets (from the start cycle) at which isequal is driven low
   task automatic run(input int nw, input int ab, input logic [63:0] bad,
                      input int e_err, input int e_pass);
      exp_t e;
      e.words = nw; e.err = e_err; e.pss = e_pass; e.lat = nw + 7;
      exp_q.push_back(e);
      start_cyc = cyc;
      for (int k = 0; k < nw + 12; k++) begin
         // extra starts while running and in the DONE cycle must be ignored
         start   = (k == 0) || (k == 3) || (k == nw + 7);
         abort   = (ab >= 0) && (k == ab);
         isequal = !bad[k];
         if (k == 2) chk("err_cleared_on_start", int'(err_count), 0);
         @(posedge clk); #1;
      end
      start = 1'b0; abort = 1'b0; isequal = 1'b1;
      chk("done_seen", exp_q.size(), 0);
      while (exp_q.size() != 0) void'(exp_q.pop_front());
      chk("err_hold", int'(err_count), e_err);
      chk("pass_hold", int'(pass), e_pass);
      chk("idle_busy", int'(busy), 0);
   endtask

   initial begin
      logic [63:0] m;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gen", int'(en_gen_data), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err_count), 0);
      chk("rst_pass", int'(pass), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run(NW, -1, 64'd0, 0, 1);                 // clean full run
      run(NW, 0, 64'd0, 0, 1);                  // start+abort in IDLE: start wins
      m = '0; m[1] = 1'b1; m[8] = 1'b1; m[12] = 1'b1; m[16] = 1'b1;
      run(NW, -1, m, 2, 0);                     // 3rd and 7th strobes bad, others ignored
      m = '0; m[6] = 1'b1; m[15] = 1'b1;
      run(NW, -1, m, 2, 0);                     // first and last strobes bad
      run(5, 5, 64'd0, 0, 1);                   // abort on 5th RUN cycle
      run(NW, -1, '1, 3, 0);                    // saturation
      run(NW, -1, 64'd0, 0, 1);                 // cleared by next start

      // reset mid-run: everything drops at once, no done
      start = 1'b1; start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_gen", int'(en_gen_data), 0);
      chk("midrst_enc", int'(en_enc), 0);
      chk("midrst_kcomp", int'(en_k_comp), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("midrst_pass", int'(pass), 0);
      run(NW, -1, 64'd0, 0, 1);                 // clean rerun

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
